// File: rtl/prbs16_pkg.sv
// Shared PRBS-16 definitions for the pattern generator and the checker:
// register width, XNOR feedback taps, generator seed, lock-up state and
// the checker state encoding.
package prbs16_pkg;

    localparam int PRBS_W = 16;

    // Tap indices into the 16-bit history for polynomial x^16+x^15+x^13+x^4
    localparam int TAP_A = 15;
    localparam int TAP_B = 14;
    localparam int TAP_C = 12;
    localparam int TAP_D = 3;

    localparam logic [PRBS_W-1:0] PRBS_SEED   = 16'h00FC;
    // All-ones is the single state an XNOR LFSR can never leave
    localparam logic [PRBS_W-1:0] PRBS_LOCKUP = 16'hFFFF;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

endpackage

// File: rtl/prbs16_checker_if.sv
// Receive-side bundle of the PRBS-16 checker: serial bit input with
// qualifier, counter clear, and lock / error status outputs.
interface prbs16_checker_if #(
    parameter int CNT_W = 32
);
    logic             bit_in;
    logic             bit_valid;
    logic             clear;
    logic             locked;
    logic             bit_err;
    logic             lock_lost;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    // Source side: feeds the bit stream and observes checker status
    modport master (
        output bit_in, bit_valid, clear,
        input  locked, bit_err, lock_lost, err_count, bit_count
    );

    // Checker side
    modport slave (
        input  bit_in, bit_valid, clear,
        output locked, bit_err, lock_lost, err_count, bit_count
    );
endinterface

// File: rtl/prbs16_step.sv
// PRBS-16 polynomial in one place: given the 16-bit history (newest bit in
// bit 0) returns the next sequence bit via the XNOR of the tap bits.
module prbs16_step
    import prbs16_pkg::*;
(
    input  logic [PRBS_W-1:0] state,
    output logic              next_bit
);

    assign next_bit = ~(state[TAP_A] ^ state[TAP_B] ^ state[TAP_C] ^ state[TAP_D]);

endmodule

// File: rtl/prbs16_checker.sv
// Serial PRBS-16 checker. Fills a 16-bit history from the line, verifies
// LOCK_COUNT self-synchronised predictions, then checks every bit against a
// free-running local reference, counting errors and dropping lock when one
// observation window holds LOSS_THRESH or more errors.
module prbs16_checker
    import prbs16_pkg::*;
#(
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    prbs16_checker_if.slave    bus
);

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int WERR_W = $clog2(WINDOW + 1);

    localparam logic [7:0]        LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0] THRESH    = WERR_W'(LOSS_THRESH);

    chk_state_t        state;
    logic [PRBS_W-1:0] hist;
    logic [3:0]        fill_cnt;
    logic [7:0]        match_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [WERR_W-1:0] win_err;
    logic              locked_r;
    logic              bit_err_r;
    logic              lock_lost_r;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  bit_cnt;

    logic              exp_bit;
    logic              mism;
    logic              chk_now;
    logic              err_now;
    logic [WERR_W-1:0] win_err_nxt;

    // Saturating increment: never wraps past all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    prbs16_step u_step (
        .state    (hist),
        .next_bit (exp_bit)
    );

    assign mism        = bus.bit_in ^ exp_bit;
    assign chk_now     = bus.bit_valid && (state == LOCKED);
    assign err_now     = chk_now && mism;
    assign win_err_nxt = win_err + WERR_W'(err_now);

    // Synchronisation FSM, history register, window tracking and status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FILL;
            hist        <= '0;
            fill_cnt    <= '0;
            match_cnt   <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            locked_r    <= 1'b0;
            bit_err_r   <= 1'b0;
            lock_lost_r <= 1'b0;
        end else begin
            bit_err_r   <= 1'b0;
            lock_lost_r <= 1'b0;
            if (bus.bit_valid) begin
                case (state)
                    FILL: begin
                        hist <= {hist[PRBS_W-2:0], bus.bit_in};
                        if (fill_cnt == 4'd15) begin
                            state     <= VERIFY;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 4'd1;
                        end
                    end
                    VERIFY: begin
                        // Self-sync: the received bit always enters the history
                        hist <= {hist[PRBS_W-2:0], bus.bit_in};
                        if (mism) begin
                            state    <= FILL;
                            fill_cnt <= '0;
                        end else if (hist != PRBS_LOCKUP) begin
                            if (match_cnt == LOCK_LAST) begin
                                state    <= LOCKED;
                                locked_r <= 1'b1;
                                win_cnt  <= '0;
                                win_err  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        // Free-running: line errors never reach the history
                        hist      <= {hist[PRBS_W-2:0], exp_bit};
                        bit_err_r <= mism;
                        if (win_cnt == WIN_LAST) begin
                            if (win_err_nxt >= THRESH) begin
                                state       <= FILL;
                                fill_cnt    <= '0;
                                locked_r    <= 1'b0;
                                lock_lost_r <= 1'b1;
                            end
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            win_err <= win_err_nxt;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

    // Saturating error and checked-bit counters; clear restarts from this cycle's contribution
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            err_cnt <= sat_inc(bus.clear ? '0 : err_cnt, err_now);
            bit_cnt <= sat_inc(bus.clear ? '0 : bit_cnt, chk_now);
        end
    end

    assign bus.locked    = locked_r;
    assign bus.bit_err   = bit_err_r;
    assign bus.lock_lost = lock_lost_r;
    assign bus.err_count = err_cnt;
    assign bus.bit_count = bit_cnt;

endmodule

// File: doc/prbs16_checker.md
Name: prbs16_checker

Overview:
Serial PRBS-16 receiver/checker: the sink-side counterpart of the team's 16-bit XNOR LFSR pattern generator (taps 16,15,13,4, seed 16'h00FC, MSB-first serial output). It self-synchronises to an incoming serial bit stream, declares lock, and then checks every bit against a free-running local reference. It also counts bit errors and declares loss of lock on excessive error density. It sits at the receive end of a link/BIST loop, fed by the generator's serial output or a deserialiser.

Parameters:
LOCK_COUNT, 32, consecutive correct predicted bits required in VERIFY before declaring lock (1..255)
WINDOW, 64, valid-bit length of the loss-of-lock observation window while LOCKED (power of two, 8..1024)
LOSS_THRESH, 8, errors within one window that force loss of lock (1..WINDOW)
CNT_W, 32, width of the saturating error and bit counters

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
bit_in  in  1  received serial data bit
bit_valid  in  1  bit_in is sampled when 1; when 0, no state advances
clear  in  1  synchronous clear of err_count and bit_count
locked  out  1  1 while in LOCKED state
bit_err  out  1  one-cycle pulse: the checked bit mismatched the reference
lock_lost  out  1  one-cycle pulse on the LOCKED->FILL transition
err_count  out  CNT_W  errors since reset or clear, saturating at all-ones
bit_count  out  CNT_W  bits checked in LOCKED since reset or clear, saturating

Behaviour:
- Reset (reset=0, async): state=FILL, hist=0, fill/match/window/window-error counters=0, all outputs 0.
- hist[15:0] is the history register; hist[0] holds the newest bit. Prediction: exp = ~(hist[15]^hist[14]^hist[12]^hist[3]). Shift operation: hist <= {hist[14:0], b}.
- All actions occur only on cycles with bit_valid=1; otherwise everything holds and pulses are 0.
- FILL: shift b=bit_in and count filled bits. On the 16th valid bit, go to VERIFY with match count 0. No comparisons are made.
- VERIFY: compare bit_in with exp, then shift b=bit_in (self-sync).
  - Mismatch -> FILL, fill count 0.
  - Match -> match count +1. When the count reaches LOCK_COUNT, go to LOCKED and clear the window counters.
  - If hist==16'hFFFF (the XNOR lock-up state), a match does not increment the count. A stuck-high line therefore never locks.
- LOCKED: compare bit_in with exp, then shift b=exp (free-running reference, no error multiplication).
  - bit_err is registered and pulses the cycle after the sampled bit when bit_in != exp.
  - bit_count +1 and window counter +1 on every valid bit. err_count +1 and window error count +1 on every mismatch. Both counters saturate and never wrap.
  - At the final bit of each window:
    - If window errors, including the current bit, >= LOSS_THRESH: go to FILL, pulse lock_lost, locked falls the next cycle.
    - Otherwise clear the window counters and remain LOCKED.
- locked is registered and equals (state==LOCKED). Lock rises exactly one cycle after the valid bit that completes LOCK_COUNT matches, i.e. after 16+LOCK_COUNT valid bits from a clean start.
- clear=1: err_count and bit_count load the current cycle's contribution (0 or 1) instead of old+increment. clear does not affect state, hist, or lock.
- Reset mid-operation: outputs drop to 0 immediately; resynchronisation restarts from FILL after release.
- The checker is seed-agnostic and locks to any phase of the 65535-bit sequence.

Decomposition:
- Shared package prbs16_pkg holds:
  - PRBS_W=16
  - tap indices 15,14,12,3
  - PRBS_SEED=16'h00FC
  - lockup constant 16'hFFFF
  - checker state enum {FILL, VERIFY, LOCKED}
- One combinational sub-module, prbs16_step (16-bit state in -> next-bit/XNOR tap out), shared with the generator so the polynomial is defined in one place.

Test Plan:
- Generator (seed 16'h00FC) drives bit_in with bit_valid=1 every cycle -> locked=1 one cycle after the 48th bit. Over 65535 further bits: err_count=0, bit_count=65535, lock_lost never pulses.
- While locked, invert one bit -> exactly one bit_err pulse one cycle later, err_count=1, locked stays 1, no follow-on errors.
- While locked, invert 8 bits inside one 64-bit window -> lock_lost pulse at that window's last bit, locked=0 next cycle. With a clean stream thereafter, locked=1 again after 48 more valid bits.
- bit_in held at 1 for 1000 valid bits -> locked never asserts, err_count=0.
- bit_valid asserted every 3rd cycle with the generator stream -> lock after 48 valid bits. bit_err/bit_count only move on valid cycles.
- Assert reset=0 mid-lock for 1 cycle -> all outputs 0 asynchronously, relock after 48 valid bits. Separately, clear=1 coincident with an injected error -> err_count=1, bit_count=1.
